// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial chunked adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } adder_state_t;

   // Number of chunk cycles needed to cover a full operand.
   function automatic int unsigned chunks(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry
// into the top bit so the caller can derive signed overflow.
module chunk_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout     = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: a + b + cin computed CHUNK bits per clock, LSB
// first, with a start/busy/done handshake and a signed-overflow flag.
module serial_chunk_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned N     = chunks(WIDTH, CHUNK);
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
   localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   adder_state_t     state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx;

   logic [31:0]      base_c;
   logic [CHUNK-1:0] a_chunk_c;
   logic [CHUNK-1:0] b_chunk_c;
   logic [CHUNK-1:0] s_c;
   logic             co_c;
   logic             cmsb_c;
   logic [WIDTH-1:0] acc_next_c;

   // Select the active chunk of each operand and merge its sum into the accumulator.
   assign base_c     = 32'(idx) * 32'(CHUNK);
   assign a_chunk_c  = CHUNK'(a_q >> base_c);
   assign b_chunk_c  = CHUNK'(b_q >> base_c);
   assign acc_next_c = (acc_q & ~(CMASK << base_c)) | (WIDTH'(s_c) << base_c);

   chunk_adder #(
      .CHUNK(CHUNK)
   ) u_chunk_adder (
      .a        (a_chunk_c),
      .b        (b_chunk_c),
      .cin      (carry_q),
      .s        (s_c),
      .cout     (co_c),
      .c_msb_in (cmsb_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  idx     <= '0;
                  acc_q   <= '0;
                  sum     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               carry_q <= co_c;
               acc_q   <= acc_next_c;
               // Results are published only once the top chunk is in.
               if (idx == LAST) begin
                  sum      <= acc_next_c;
                  cout     <= co_c;
                  overflow <= co_c ^ cmsb_c;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench for serial_chunk_adder: three configurations (8/2, 4/1, 4/4)
// checked against an arithmetic reference model, including latency and busy.
module tb_serial_chunk_adder;

   localparam int NDUT = 3;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         due;
   } exp_t;

   exp_t q[NDUT][$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start_v[NDUT];
   logic [7:0] a_v[NDUT];
   logic [7:0] b_v[NDUT];
   logic       cin_v[NDUT];
   logic       busy_v[NDUT];
   logic       done_v[NDUT];
   logic       cout_v[NDUT];
   logic       ovf_v[NDUT];
   logic [7:0] sum0;
   logic [3:0] sum1;
   logic [3:0] sum2;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int busy_left[NDUT];

   serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0]), .overflow(ovf_v[0]));

   serial_chunk_adder #(.WIDTH(4), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1]), .overflow(ovf_v[1]));

   serial_chunk_adder #(.WIDTH(4), .CHUNK(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][3:0]), .b(b_v[2][3:0]), .cin(cin_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout_v[2]), .overflow(ovf_v[2]));

   function automatic int w_of(input int k);
      return (k == 0) ? 8 : 4;
   endfunction

   function automatic int n_of(input int k);
      return (k == 2) ? 1 : 4;
   endfunction

   function automatic logic [7:0] sum_of(input int k);
      case (k)
         0:       return sum0;
         1:       return {4'h0, sum1};
         default: return {4'h0, sum2};
      endcase
   endfunction

   // Reference: unsigned sum for sum/cout, signed sum range test for overflow.
   function automatic exp_t model(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin);
      exp_t e;
      int w   = w_of(k);
      int ua  = int'(a);
      int ub  = int'(b);
      int ci  = cin ? 1 : 0;
      int tot = ua + ub + ci;
      int sa  = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      int sb  = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      int st  = sa + sb + ci;
      e.a    = a;
      e.b    = b;
      e.cin  = cin;
      e.sum  = 8'(tot % (1 << w));
      e.cout = (tot >= (1 << w));
      e.ovf  = (st > (1 << (w - 1)) - 1) || (st < -(1 << (w - 1)));
      e.due  = 0;
      return e;
   endfunction

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s dut%0d @cyc %0d: got %0h, want %0h", nm, k, cyc, act, exp_v);
      end
   endtask

   task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin);
      int   budget = 50;
      exp_t e;
      logic [7:0] mask = (w_of(k) == 8) ? 8'hFF : 8'h0F;
      @(negedge clk);
      a_v[k]     = a & mask;
      b_v[k]     = b & mask;
      cin_v[k]   = cin;
      start_v[k] = 1'b1;
      while (busy_v[k] && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (busy_v[k]) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout dut%0d: busy still %0b, want 0", k, busy_v[k]);
         start_v[k] = 1'b0;
         return;
      end
      e = model(k, a & mask, b & mask, cin);
      e.due = cyc + 1 + n_of(k);
      q[k].push_back(e);
      busy_left[k] = n_of(k);
   endtask

   // Drops start and scribbles the operands to show they are ignored.
   task automatic idle(input int k, input int n);
      repeat (n) begin
         @(negedge clk);
         start_v[k] = 1'b0;
         a_v[k]     = 8'($urandom);
         b_v[k]     = 8'($urandom);
         cin_v[k]   = 1'($urandom);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: busy every cycle, and result/latency whenever done is presented.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (!rst) begin
         for (int k = 0; k < NDUT; k++) begin
            check("busy", k, 32'(busy_v[k]), 32'(busy_left[k] > 0));
            if (busy_left[k] > 0) busy_left[k]--;
            if (done_v[k]) begin
               if (q[k].size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL spurious_done dut%0d @cyc %0d: got done=1, want 0", k, cyc);
               end else begin
                  e = q[k].pop_front();
                  check("sum", k, 32'(sum_of(k)), 32'(e.sum));
                  check("cout", k, 32'(cout_v[k]), 32'(e.cout));
                  check("overflow", k, 32'(ovf_v[k]), 32'(e.ovf));
                  check("latency", k, 32'(cyc), 32'(e.due));
               end
            end else if (q[k].size() > 0 && cyc >= q[k][0].due) begin
               e = q[k].pop_front();
               vectors++;
               miscompares++;
               $display("FAIL missing_done dut%0d a=%0h b=%0h: got done=0 at cyc %0d, want 1", k, e.a, e.b, cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         start_v[k]   = 1'b0;
         a_v[k]       = 8'h00;
         b_v[k]       = 8'h00;
         cin_v[k]     = 1'b0;
         busy_left[k] = 0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         check("rst_busy", k, 32'(busy_v[k]), 32'h0);
         check("rst_done", k, 32'(done_v[k]), 32'h0);
         check("rst_sum", k, 32'(sum_of(k)), 32'h0);
         check("rst_cout", k, 32'(cout_v[k]), 32'h0);
         check("rst_ovf", k, 32'(ovf_v[k]), 32'h0);
      end

      // Directed corner cases on the 8/2 configuration.
      issue(0, 8'h7F, 8'h01, 1'b0); idle(0, 6);
      issue(0, 8'hFF, 8'h01, 1'b0); idle(0, 6);
      issue(0, 8'h80, 8'h80, 1'b1); idle(0, 6);
      issue(0, 8'h12, 8'h34, 1'b0);
      issue(0, 8'hAA, 8'h55, 1'b1); idle(0, 6);

      // Abort an operation in its second RUN cycle.
      issue(0, 8'h5A, 8'h33, 1'b0);
      @(negedge clk); start_v[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         q[k].delete();
         busy_left[k] = 0;
      end
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 0, 32'(busy_v[0]), 32'h0);
      check("abort_done", 0, 32'(done_v[0]), 32'h0);
      check("abort_sum", 0, 32'(sum0), 32'h0);
      check("abort_cout", 0, 32'(cout_v[0]), 32'h0);
      check("abort_ovf", 0, 32'(ovf_v[0]), 32'h0);
      issue(0, 8'h05, 8'h03, 1'b0); idle(0, 6);

      fork
         begin
            for (int i = 0; i < 512; i++)
               issue(1, 8'(i % 16), 8'((i / 16) % 16), 1'(i / 256));
            idle(1, 1);
         end
         begin
            for (int i = 0; i < 512; i++)
               issue(2, 8'(i % 16), 8'((i / 16) % 16), 1'(i / 256));
            idle(2, 1);
         end
         begin
            repeat (60) begin
               issue(0, 8'($urandom), 8'($urandom), 1'($urandom));
               if ($urandom_range(0, 2) == 0) idle(0, $urandom_range(1, 3));
            end
            idle(0, 1);
         end
      join

      for (int t = 0; t < 20 && (q[0].size() + q[1].size() + q[2].size()) > 0; t++)
         @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         if (q[k].size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain dut%0d: got %0d pending results, want 0", k, q[k].size());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
